somador_serial: RTL and testbench
=================================

// Module: somador_serial
// PURPOSE
//   Bit-serial N-bit adder built around one somador_completo instance plus a carry flip-flop.
//   Operands are captured on a START pulse and summed LSB-first, one bit per clock.
//   The full N-bit sum and carry-out are then presented on registered outputs with a one-cycle DONE strobe.
//   It trades N cycles of latency for a single full-adder cell. It sits directly downstream of the
//   operand source and feeds result consumers.
// PARAMETERS
//   N  default 4  operand/sum width in bits; legal range 1..32
// PORTS
//   CLK    in   1   clock; all state changes on the rising edge
//   RST    in   1   asynchronous, active-high reset
//   START  in   1   request; sampled only in IDLE
//   A      in   N   operand A; captured on accepted START
//   B      in   N   operand B; captured on accepted START
//   CIN    in   1   carry-in; captured on accepted START
//   S      out  N   registered sum; holds last result
//   COUT   out  1   registered carry-out of last result
//   BUSY   out  1   high while an addition is in progress
//   DONE   out  1   one-cycle strobe: S/COUT just updated
// BEHAVIOUR
//   Reset: state=IDLE; S=0, COUT=0, BUSY=0, DONE=0; internal shift regs, carry FF and bit counter = 0.
//     Applies immediately, including mid-operation; the in-flight addition is discarded and
//     no DONE is produced for it.
//   FSM states:
//     IDLE -> SOMA on an edge with START=1: load A, B into shift regs, carry<=CIN, cnt<=0, BUSY<=1.
//     SOMA: each edge feeds shift-reg bit0 of A and B, plus the carry FF, into somador_completo.
//       S bit shifts into the result shift reg from the MSB side; COUT is written back into the carry FF;
//       the A/B regs shift right; cnt increments.
//       On the edge where cnt==N-1: S<=completed result, COUT<=final carry, DONE<=1, BUSY<=0,
//       and the state goes to IDLE.
//   Latency: START accepted at edge k -> DONE=1 and new S/COUT visible after edge k+N.
//     DONE stays high for exactly one cycle.
//   START while BUSY=1: ignored; the operation is not restarted and operands are not re-captured.
//   START=1 in the cycle DONE=1 (state already IDLE): accepted. Back-to-back throughput is one
//     result per N+1 cycles.
//   A/B/CIN changes after capture have no effect on the running sum.
//   Arithmetic: {COUT,S} = A + B + CIN, unsigned, N+1 bits exact; no overflow flag.
//   S/COUT change only on DONE edges (and reset); they hold through the next operation.
//   N=1: SOMA lasts one edge; DONE follows START by one edge.
// TESTING
//   N=4, A=4'h3, B=4'h5, CIN=0, START pulse -> after 4 edges DONE=1 for 1 cycle, S=4'h8, COUT=0, BUSY low.
//   N=4, A=4'hF, B=4'hF, CIN=1 -> S=4'hF, COUT=1; also A=4'hF, B=4'h0, CIN=1 -> S=0, COUT=1 (full carry ripple).
//   START re-pulsed at cycle 2 of a run with different operands -> first result unaffected,
//     exactly one DONE, second request dropped.
//   START held high continuously with A=1, B=1 -> DONE every 5 cycles, S=2 each time.
//   RST asserted asynchronously at cycle 2 of a run -> outputs 0 immediately, no DONE;
//     a fresh START after release gives the correct sum.
//   Exhaustive 8-case CIN/A[0]/B[0] sweep with N=1 -> {COUT,S} matches the full-adder truth table.

Source files
------------

// File: rtl/somador_serial.sv
// somador_serial: bit-serial N-bit adder (one full-adder cell plus a carry flip-flop).
//   A pulse on START captures A, B and CIN. The operands are then summed LSB-first, one bit
//   per clock. {COUT,S} is updated together with a one-cycle DONE strobe.
// Parameters:
//   N      operand/sum width in bits, 1..32
// Ports:
//   CLK    clock, rising edge
//   RST    asynchronous, active-high reset
//   START  request, sampled only while idle
//   A, B   operands, captured on an accepted START
//   CIN    carry-in, captured on an accepted START
//   S      registered sum of the last completed addition
//   COUT   registered carry-out of the last completed addition
//   BUSY   high while an addition is in progress
//   DONE   one-cycle strobe: S/COUT were just updated

module somador_completo (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

module somador_serial #(
  parameter int unsigned N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic [N-1:0] S,
  output logic         COUT,
  output logic         BUSY,
  output logic         DONE
);

  typedef enum logic {IDLE, SOMA} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] res_q, res_d;
  logic [N-1:0] s_q, s_d;
  logic         carry_q, carry_d;
  logic         cout_q, cout_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [5:0]   cnt_q, cnt_d;

  logic         fa_s, fa_co;
  logic [N-1:0] res_sh;

  somador_completo u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_co)
  );

  // Result register with the new sum bit entering at the MSB. Shifting the
  // N+1-bit concatenation keeps the expression legal for N=1.
  assign res_sh = N'({fa_s, res_q} >> 1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SOMA;
        end
      end
      SOMA: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        res_d   = res_sh;
        cnt_d   = cnt_q + 6'd1;
        // Last bit: publish the shifted-in result directly so S is valid
        // in the same cycle DONE rises.
        if (cnt_q == 6'(N - 1)) begin
          s_d     = res_sh;
          cout_d  = fa_co;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign S    = s_q;
  assign COUT = cout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_somador_serial.sv
module tb_somador_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, start4, cin4, cout4, busy4, done4;
  logic [3:0] a4, b4, s4;
  logic       rst1, start1, cin1, cout1, busy1, done1;
  logic [0:0] a1, b1, s1;

  somador_serial #(.N(4)) dut4 (
    .CLK(clk), .RST(rst4), .START(start4), .A(a4), .B(b4), .CIN(cin4),
    .S(s4), .COUT(cout4), .BUSY(busy4), .DONE(done4)
  );

  somador_serial #(.N(1)) dut1 (
    .CLK(clk), .RST(rst1), .START(start1), .A(a1), .B(b1), .CIN(cin1),
    .S(s1), .COUT(cout1), .BUSY(busy1), .DONE(done1)
  );

  typedef struct {
    logic [4:0] res;
    int         cyc;
  } exp_t;

  exp_t       q4[$];
  exp_t       q1[$];
  logic [4:0] last4 = '0;
  logic [4:0] last1 = '0;
  int         cyc   = 0;
  int         vecs  = 0;
  int         errs  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every DONE pops one expected result; otherwise the outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst4) last4 = '0;
    if (done4) begin
      if (q4.size() == 0) chk("spurious_done4", done4, 0);
      else begin
        e = q4.pop_front();
        chk("sum4", {cout4, s4}, e.res);
        chk("lat4", cyc, e.cyc);
        chk("busy_at_done4", busy4, 0);
        last4 = e.res;
      end
    end else chk("hold4", {cout4, s4}, last4);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst1) last1 = '0;
    if (done1) begin
      if (q1.size() == 0) chk("spurious_done1", done1, 0);
      else begin
        e = q1.pop_front();
        chk("sum1", {cout1, s1}, e.res);
        chk("lat1", cyc, e.cyc);
        chk("busy_at_done1", busy1, 0);
        last1 = e.res;
      end
    end else chk("hold1", {cout1, s1}, last1);
  end

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] exp);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    q4.push_back('{res: exp, cyc: cyc + 1 + 4});
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = ~a4; b4 = ~b4; cin4 = ~cin4;
  endtask

  task automatic issue1(input logic a, input logic b, input logic c, input logic [4:0] exp);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    q1.push_back('{res: exp, cyc: cyc + 1 + 1});
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
  endtask

  task automatic wait_idle4();
    int n = 0;
    while ((q4.size() != 0 || busy4) && n < 40) begin
      @(posedge clk); n++;
    end
    if (n >= 40) chk("timeout4", q4.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle1();
    int n = 0;
    while ((q1.size() != 0 || busy1) && n < 40) begin
      @(posedge clk); n++;
    end
    if (n >= 40) chk("timeout1", q1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [1:0] ft [8];
  logic [2:0] v;
  int         c0;

  initial begin
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    // index = {CIN, A, B}; value = {COUT, S}
    ft = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    #2;
    chk("rst_s4", s4, 0);
    chk("rst_cout4", cout4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_s1", s1, 0);
    chk("rst_busy1", busy1, 0);
    @(posedge clk); #1;
    rst4 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    issue4(4'h3, 4'h5, 1'b0, 5'h08); wait_idle4();
    issue4(4'hF, 4'hF, 1'b1, 5'h1F); wait_idle4();
    issue4(4'hF, 4'h0, 1'b1, 5'h10); wait_idle4();
    issue4(4'h9, 4'h4, 1'b1, 5'h0E); wait_idle4();
    issue4(4'h8, 4'h8, 1'b0, 5'h10); wait_idle4();
    issue4(4'hA, 4'h3, 1'b0, 5'h0D); wait_idle4();

    // Second START during the run must be dropped.
    issue4(4'h2, 4'h3, 1'b0, 5'h05);
    @(posedge clk); #1;
    a4 = 4'hE; b4 = 4'hE; cin4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_idle4();

    // START held high: a new run is accepted in every DONE cycle.
    a4 = 4'h1; b4 = 4'h1; cin4 = 1'b0; start4 = 1'b1;
    c0 = cyc;
    q4.push_back('{res: 5'h02, cyc: c0 + 5});
    q4.push_back('{res: 5'h02, cyc: c0 + 10});
    q4.push_back('{res: 5'h02, cyc: c0 + 15});
    repeat (11) @(posedge clk);
    #1 start4 = 1'b0;
    wait_idle4();

    // Asynchronous reset in the middle of a run: no DONE for the aborted sum.
    a4 = 4'h6; b4 = 4'h7; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #2;
    rst4 = 1'b1;
    #1;
    chk("midrst_s4", s4, 0);
    chk("midrst_cout4", cout4, 0);
    chk("midrst_busy4", busy4, 0);
    chk("midrst_done4", done4, 0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    issue4(4'hC, 4'h5, 1'b1, 5'h12); wait_idle4();

    // N=1 full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      issue1(v[1], v[0], v[2], {3'b000, ft[i]});
      wait_idle1();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
